bytebeat_voice_scheduler: RTL



---
 rtl/bytebeat_pkg.sv | 23 ++
 rtl/bytebeat_frame_timer.sv | 33 +++
 rtl/bytebeat_voice_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bytebeat_pkg.sv
// Shared types for the bytebeat voice scheduler.
// FSM states, midscale PCM constant and the parameter bundle layout.
package bytebeat_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    WAIT,
    PUBLISH
  } state_t;

  localparam logic [7:0] PCM_MID = 8'h80;
  localparam int         PARAM_W = 4;

  typedef struct packed {
    logic [PARAM_W-1:0] d;
    logic [PARAM_W-1:0] c;
    logic [PARAM_W-1:0] b;
    logic [PARAM_W-1:0] a;
  } params_t;

endpackage

// File: rtl/bytebeat_frame_timer.sv
// Sample-frame divider: counts 0..SAMPLE_DIV-1 and wraps.
// tick_o is high during the last count of every frame.
module bytebeat_frame_timer #(
    parameter int SAMPLE_DIV = 512
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int CW = $clog2(SAMPLE_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CW'(SAMPLE_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bytebeat_voice_scheduler.sv
// Shares one bytebeat core among NUM_VOICES voices, one request per
// enabled voice per frame; all samples publish together on frame_done.
module bytebeat_voice_scheduler
    import bytebeat_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_DIV = 512,
    parameter int PARAM_W    = 4,
    parameter int PCM_W      = 8,
    parameter int TIMEOUT    = 64,
    localparam int VW        = $clog2(NUM_VOICES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_VOICES-1:0]       voice_en,
    input  logic [PARAM_W-1:0]          knob_a,
    input  logic [PARAM_W-1:0]          knob_b,
    input  logic [PARAM_W-1:0]          knob_c,
    input  logic [PARAM_W-1:0]          knob_d,
    output logic                        req_vld,
    input  logic                        req_rdy,
    output logic [VW-1:0]               req_voice,
    output logic [4*PARAM_W-1:0]        req_knobs,
    input  logic                        resp_vld,
    output logic                        resp_rdy,
    input  logic [PCM_W-1:0]            resp_pcm,
    output logic [NUM_VOICES*PCM_W-1:0] pcm_out,
    output logic                        frame_done,
    output logic                        overrun,
    output logic                        timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PCM_W-1:0] MID = {1'b1, {(PCM_W-1){1'b0}}};

    state_t                        state_q;
    logic [VW-1:0]                 v_q;
    logic [NUM_VOICES-1:0]         en_q;
    logic [4*PARAM_W-1:0]          knobs_q;
    logic                          req_vld_q;
    logic [TW-1:0]                 wcnt_q;
    logic [NUM_VOICES*PCM_W-1:0]   shadow_q;
    logic [NUM_VOICES*PCM_W-1:0]   pcm_q;
    logic                          done_q;
    logic                          ovr_q;
    logic                          to_q;

    logic                          tick;
    logic                          last_v;
    state_t                        adv_state;
    logic [VW-1:0]                 adv_v;

    bytebeat_frame_timer #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .tick_o(tick)
    );

    assign last_v    = (v_q == VW'(NUM_VOICES - 1));
    assign adv_state = last_v ? PUBLISH : SCAN;
    assign adv_v     = last_v ? v_q : v_q + 1'b1;

    assign req_vld    = req_vld_q;
    assign req_voice  = v_q;
    assign req_knobs  = knobs_q;
    assign resp_rdy   = 1'b1;
    assign pcm_out    = pcm_q;
    assign frame_done = done_q;
    assign overrun    = ovr_q;
    assign timeout    = to_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            v_q       <= '0;
            en_q      <= '0;
            knobs_q   <= '0;
            req_vld_q <= 1'b0;
            wcnt_q    <= '0;
            shadow_q  <= {NUM_VOICES{MID}};
            pcm_q     <= {NUM_VOICES{MID}};
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A tick that lands mid-frame is dropped, not queued.
            if (tick && state_q != IDLE) begin
                ovr_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_q  <= SCAN;
                        v_q      <= '0;
                        en_q     <= voice_en;
                        knobs_q  <= {knob_d, knob_c, knob_b, knob_a};
                        shadow_q <= pcm_q;
                    end
                end
                SCAN: begin
                    if (en_q[v_q]) begin
                        state_q   <= ISSUE;
                        req_vld_q <= 1'b1;
                    end else begin
                        shadow_q[v_q*PCM_W +: PCM_W] <= MID;
                        state_q <= adv_state;
                        v_q     <= adv_v;
                    end
                end
                ISSUE: begin
                    if (req_rdy) begin
                        req_vld_q <= 1'b0;
                        wcnt_q    <= '0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    // A response on the deadline cycle still counts.
                    if (resp_vld) begin
                        shadow_q[v_q*PCM_W +: PCM_W] <= resp_pcm;
                        state_q <= adv_state;
                        v_q     <= adv_v;
                    end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                        to_q    <= 1'b1;
                        state_q <= adv_state;
                        v_q     <= adv_v;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                PUBLISH: begin
                    pcm_q   <= shadow_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
